exe: RTL and testbench

Execute stage of the RV32 core. It consumes the ID/EX pipeline register outputs (operands, instruction word, write-back control) and computes the RV32I integer result and the RV32M multiply/divide result. It drives the EX/MEM register. Multiplies finish in one cycle. Divides use an iterative FSM that asks the hazard unit to stall while busy.

---
 rtl/exe_pkg.sv | 46 ++++
 rtl/exe_div.sv | 110 +++++++++++
 rtl/exe.sv | 128 ++++++++++++
 tb/tb_exe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared constants for the RV32 execute stage: widths, opcode/funct codes,
// divider state encoding and a two's-complement helper.
package exe_pkg;

  localparam int RDATA_WIDTH = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic [RDATA_WIDTH-1:0] negate_if(input logic [RDATA_WIDTH-1:0] v,
                                                       input logic neg);
    if (neg) begin
      return ~v + RDATA_WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/exe_div.sv
// Iterative restoring divider: works on magnitudes, one quotient bit per cycle,
// sign fix-up applied on the DONE-state result.
module exe_div
  import exe_pkg::*;
#(
  parameter int DIV_STEPS = RDATA_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [RDATA_WIDTH-1:0] op1_i,
  input  logic [RDATA_WIDTH-1:0] op2_i,
  input  logic [2:0]             funct3_i,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [RDATA_WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  div_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RDATA_WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic                   q_neg_q, q_neg_d, r_neg_q, r_neg_d, rem_sel_q, rem_sel_d;
  logic                   is_signed;
  logic [RDATA_WIDTH:0]   rem_shift, trial;

  // Next-state, datapath step and operand capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_sel_d = rem_sel_q;
    is_signed = (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    // quo_q doubles as the dividend shift register
    rem_shift = {rem_q, quo_q[RDATA_WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          quo_d     = negate_if(op1_i, is_signed & op1_i[RDATA_WIDTH-1]);
          dvsr_d    = negate_if(op2_i, is_signed & op2_i[RDATA_WIDTH-1]);
          q_neg_d   = is_signed & (op1_i[RDATA_WIDTH-1] ^ op2_i[RDATA_WIDTH-1]);
          r_neg_d   = is_signed & op1_i[RDATA_WIDTH-1];
          rem_sel_d = (funct3_i == F3_REM) || (funct3_i == F3_REMU);
          cnt_d     = '0;
          rem_d     = '0;
          state_d   = DIV_BUSY;
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (flush_i) begin
          state_d = DIV_IDLE;
        end else begin
          if (trial[RDATA_WIDTH]) begin
            rem_d = rem_shift[RDATA_WIDTH-1:0];
            quo_d = {quo_q[RDATA_WIDTH-2:0], 1'b0};
          end else begin
            rem_d = trial[RDATA_WIDTH-1:0];
            quo_d = {quo_q[RDATA_WIDTH-2:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = DIV_DONE;
          end else begin
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  assign busy_o   = (state_q == DIV_BUSY);
  assign done_o   = (state_q == DIV_DONE);
  assign result_o = rem_sel_q ? negate_if(rem_q, r_neg_q) : negate_if(quo_q, q_neg_q);

endmodule

// File: rtl/exe.sv
// RV32IM execute stage: combinational ALU and multiplier, same-cycle divide
// special cases, and the iterative divider for everything else.
module exe
  import exe_pkg::*;
#(
  parameter int DIV_STEPS = RDATA_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RDATA_WIDTH-1:0] op1_i,
  input  logic [RDATA_WIDTH-1:0] op2_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   flush_i,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   stall_req_o
);

  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic                   alt, is_m, is_div, div_rem, div_special, div_by_zero;
  logic                   div_start, div_busy, div_done, mul_sa, mul_sb;
  logic [4:0]             shamt;
  logic [RDATA_WIDTH-1:0] alu_res, mul_res, div_res, special_res, result;
  logic signed [32:0]     mul_a, mul_b;
  logic signed [65:0]     mul_p;
  logic                   unused_bits;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign alt         = inst_i[30];
  assign shamt       = op2_i[4:0];
  assign is_m        = (opcode == OPC_OP) && (inst_i[31:25] == FUNCT7_MULDIV);
  assign is_div      = is_m && funct3[2];
  assign div_rem     = (funct3 == F3_REM) || (funct3 == F3_REMU);
  assign div_by_zero = (op2_i == '0);
  assign div_special = div_by_zero ||
                       (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                        (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF));
  assign unused_bits = ^{inst_i[24:15], inst_i[11:7], mul_p[65:64]};

  // Integer ALU; opcodes other than OP/OP-IMM fall back to an add.
  always_comb begin
    alu_res = op1_i + op2_i;
    if ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) begin
      case (funct3)
        F3_ADD_SUB: begin
          if ((opcode == OPC_OP) && alt) alu_res = op1_i - op2_i;
          else                           alu_res = op1_i + op2_i;
        end
        F3_SLL:     alu_res = op1_i << shamt;
        F3_SLT:     alu_res = {31'd0, ($signed(op1_i) < $signed(op2_i))};
        F3_SLTU:    alu_res = {31'd0, (op1_i < op2_i)};
        F3_XOR:     alu_res = op1_i ^ op2_i;
        F3_SRL_SRA: begin
          if (alt) alu_res = $signed(op1_i) >>> shamt;
          else     alu_res = op1_i >> shamt;
        end
        F3_OR:      alu_res = op1_i | op2_i;
        F3_AND:     alu_res = op1_i & op2_i;
        default:    alu_res = op1_i + op2_i;
      endcase
    end else begin
      alu_res = op1_i + op2_i;
    end
  end

  // 33x33 signed multiply with per-operand sign extension chosen by funct3.
  always_comb begin
    mul_sa = 1'b0;
    mul_sb = 1'b0;
    case (funct3)
      F3_MULH:   begin mul_sa = 1'b1; mul_sb = 1'b1; end
      F3_MULHSU: mul_sa = 1'b1;
      F3_MUL, F3_MULHU: mul_sa = 1'b0;
      default:   mul_sa = 1'b0;
    endcase
    mul_a   = {mul_sa & op1_i[31], op1_i};
    mul_b   = {mul_sb & op2_i[31], op2_i};
    mul_p   = mul_a * mul_b;
    mul_res = (funct3 == F3_MUL) ? mul_p[31:0] : mul_p[63:32];
  end

  exe_div #(
    .DIV_STEPS(DIV_STEPS)
  ) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (div_start),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .funct3_i (funct3),
    .flush_i  (flush_i),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .result_o (div_res)
  );

  // Result select between ALU, multiplier, divide special case and divider.
  always_comb begin
    if (div_by_zero) begin
      if (div_rem) special_res = op1_i;
      else         special_res = 32'hFFFF_FFFF;
    end else begin
      if (div_rem) special_res = 32'h0000_0000;
      else         special_res = 32'h8000_0000;
    end
    result = alu_res;
    if (is_div) begin
      if (div_special) result = special_res;
      else             result = div_res;
    end else if (is_m) begin
      result = mul_res;
    end else begin
      result = alu_res;
    end
  end

  assign div_start   = is_div & ~div_special & ~div_busy & ~div_done & ~flush_i & ~rst_i;
  assign stall_req_o = div_start | (div_busy & ~rst_i);
  assign reg_we_o    = reg_we_i & ~(div_start | div_busy) & ~(div_done & flush_i);
  assign reg_wdata_o = result;
  assign reg_waddr_o = reg_waddr_i;

endmodule

// File: tb/tb_exe.sv
// Self-checking bench for exe: a behavioural RV32IM model plus timing rules,
// compared every cycle, with directed literal checks on top.
module tb_exe;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_i, flush_i, reg_we_i;
  logic [31:0] op1_i, op2_i, inst_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_o;
  logic        reg_we_o, stall_req_o;
  logic [4:0]  reg_waddr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int issue_cycle = 0;

  exe dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .inst_i      (inst_i),
    .reg_we_i    (reg_we_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .stall_req_o (stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic logic normal_div(input logic [31:0] inst, input logic [31:0] a,
                                      input logic [31:0] b);
    logic sgn;
    sgn = ~inst[12];
    if (inst[6:0] != OP || inst[31:25] != 7'b0000001 || !inst[14]) return 1'b0;
    if (b == 32'd0) return 1'b0;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
    return 1'b1;
  endfunction

  // Architectural result of one instruction, straight from the ISA rules.
  function automatic logic [31:0] model(input logic [31:0] inst, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [6:0] opc;
    logic [2:0] f3;
    int ia, ib;
    longint pa, pb;
    longint unsigned pu;
    opc = inst[6:0];
    f3  = inst[14:12];
    ia  = a;
    ib  = b;
    if (opc == OP && inst[31:25] == 7'b0000001) begin
      case (f3)
        3'd0: return a * b;
        3'd1: begin pa = ia; pb = ib; pa = pa * pb; return pa[63:32]; end
        3'd2: begin pa = ia; pb = {32'd0, b}; pa = pa * pb; return pa[63:32]; end
        3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
        default: begin
          if (b == 32'd0) begin
            if (f3[1]) return a;
            return 32'hFFFF_FFFF;
          end
          if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              if (f3[1]) return 32'd0;
              return 32'h8000_0000;
            end
            if (f3[1]) return ia % ib;
            return ia / ib;
          end
          if (f3[1]) return a % b;
          return a / b;
        end
      endcase
    end
    if (opc == OP || opc == OP_IMM) begin
      case (f3)
        3'd0: begin
          if (opc == OP && inst[30]) return a - b;
          return a + b;
        end
        3'd1: return a << b[4:0];
        3'd2: return (ia < ib) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: begin
          if (inst[30]) return ia >>> b[4:0];
          return a >> b[4:0];
        end
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    return a + b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Per-cycle compare against the model: a normal divide stalls for ages 0..32
  // and writes back at age 33; everything else is same-cycle.
  always @(negedge clk) begin : cmp_proc
    int age;
    age = cycle - issue_cycle;
    if (!rst_i) begin
      check("waddr", {27'd0, reg_waddr_o}, {27'd0, reg_waddr_i});
      if (normal_div(inst_i, op1_i, op2_i)) begin
        check("div stall", {31'd0, stall_req_o}, {31'd0, (age <= 32)});
        check("div we", {31'd0, reg_we_o}, {31'd0, (age == 33) ? reg_we_i : 1'b0});
        if (age == 33) check("div result", reg_wdata_o, model(inst_i, op1_i, op2_i));
      end else begin
        check("stall", {31'd0, stall_req_o}, 32'd0);
        check("we", {31'd0, reg_we_o}, {31'd0, reg_we_i});
        check("result", reg_wdata_o, model(inst_i, op1_i, op2_i));
      end
    end
  end

  task automatic issue(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic [4:0] wa);
    @(posedge clk);
    #1;
    inst_i      = inst;
    op1_i       = a;
    op2_i       = b;
    reg_we_i    = we;
    reg_waddr_i = wa;
    issue_cycle = cycle;
  endtask

  task automatic run_comb(input string name, input logic [31:0] inst, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    issue(inst, a, b, 1'b1, 5'd4);
    @(negedge clk);
    check(name, reg_wdata_o, exp);
    check({name, " stall"}, {31'd0, stall_req_o}, 32'd0);
  endtask

  task automatic run_div(input string name, input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int stalls;
    logic we_seen;
    stalls  = 0;
    we_seen = 1'b0;
    issue(inst, a, b, 1'b1, 5'd5);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (i < 33) begin
        stalls  = stalls + int'(stall_req_o);
        we_seen = we_seen | reg_we_o;
      end
    end
    check({name, " stall cycles"}, 32'(stalls), 32'd33);
    check({name, " we while busy"}, {31'd0, we_seen}, 32'd0);
    check(name, reg_wdata_o, exp);
    check({name, " we at done"}, {31'd0, reg_we_o}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; reg_we_i = 1'b0; reg_waddr_i = 5'd0;
    inst_i = NOP; op1_i = 32'd0; op2_i = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset stall", {31'd0, stall_req_o}, 32'd0);
    check("reset we", {31'd0, reg_we_o}, 32'd0);
    check("reset wdata", reg_wdata_o, 32'd0);

    run_comb("ADD 5+-3", rtype(7'b0000000, 3'b000, OP), 32'd5, 32'hFFFF_FFFD, 32'd2);
    run_comb("SRA", rtype(7'b0100000, 3'b101, OP), 32'h8000_0000, 32'd4, 32'hF800_0000);
    run_comb("MULH", rtype(7'b0000001, 3'b001, OP), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    run_comb("MULHU", rtype(7'b0000001, 3'b011, OP), 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE);
    run_comb("DIVU by 0", rtype(7'b0000001, 3'b101, OP), 32'd1234, 32'd0, 32'hFFFF_FFFF);
    run_comb("DIV ovf", rtype(7'b0000001, 3'b100, OP), 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000);

    run_div("DIV -7/2", rtype(7'b0000001, 3'b100, OP), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("REM -7/2", rtype(7'b0000001, 3'b110, OP), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("DIV 100/-7", rtype(7'b0000001, 3'b100, OP), 32'd100, 32'hFFFF_FFF9,
            32'hFFFF_FFF2);
    run_div("REM 100/-7", rtype(7'b0000001, 3'b110, OP), 32'd100, 32'hFFFF_FFF9, 32'd2);

    // flush in the middle of a divide
    issue(rtype(7'b0000001, 3'b100, OP), 32'd1000, 32'd3, 1'b1, 5'd7);
    repeat (11) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    check("stall in flush cycle", {31'd0, stall_req_o}, 32'd1);
    issue(rtype(7'b0000000, 3'b000, OP), 32'd10, 32'd20, 1'b1, 5'd8);
    flush_i = 1'b0;
    @(negedge clk);
    check("stall after flush", {31'd0, stall_req_o}, 32'd0);
    check("ADD after flush", reg_wdata_o, 32'd30);
    check("ADD after flush we", {31'd0, reg_we_o}, 32'd1);

    // reset in the middle of a divide
    issue(rtype(7'b0000001, 3'b101, OP), 32'd5000, 32'd13, 1'b1, 5'd9);
    repeat (21) @(posedge clk);
    #1;
    rst_i = 1'b1; inst_i = NOP; op1_i = 32'd0; op2_i = 32'd0; reg_we_i = 1'b0;
    issue_cycle = cycle;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("stall after mid-divide reset", {31'd0, stall_req_o}, 32'd0);
    check("we after mid-divide reset", {31'd0, reg_we_o}, 32'd0);

    run_div("DIVU 100/7", rtype(7'b0000001, 3'b101, OP), 32'd100, 32'd7, 32'd14);
    run_div("DIVU 9/3", rtype(7'b0000001, 3'b101, OP), 32'd9, 32'd3, 32'd3);

    // model-checked sweep of the remaining operations
    vecs.push_back('{rtype(7'b0100000, 3'b000, OP), 32'd3, 32'd10});
    vecs.push_back('{rtype(7'b0000000, 3'b001, OP), 32'h0000_00F1, 32'd36});
    vecs.push_back('{rtype(7'b0000000, 3'b010, OP), 32'hFFFF_FFFF, 32'd1});
    vecs.push_back('{rtype(7'b0000000, 3'b011, OP), 32'hFFFF_FFFF, 32'd1});
    vecs.push_back('{rtype(7'b0000000, 3'b100, OP), 32'hA5A5_0F0F, 32'h5A5A_FFFF});
    vecs.push_back('{rtype(7'b0000000, 3'b101, OP), 32'h8000_0000, 32'd31});
    vecs.push_back('{rtype(7'b0000000, 3'b110, OP), 32'h1200_0034, 32'h0056_7800});
    vecs.push_back('{rtype(7'b0000000, 3'b111, OP), 32'hF0F0_F0F0, 32'h0FF0_0FF0});
    vecs.push_back('{rtype(7'b0100000, 3'b000, OP_IMM), 32'd100, 32'hFFFF_FC00});
    vecs.push_back('{rtype(7'b0100000, 3'b101, OP_IMM), 32'h8765_4321, 32'd8});
    vecs.push_back('{rtype(7'b0000000, 3'b000, LUI), 32'h0001_0000, 32'h0000_0100});
    vecs.push_back('{rtype(7'b0000001, 3'b000, OP), 32'hFFFF_FFFE, 32'd7});
    vecs.push_back('{rtype(7'b0000001, 3'b010, OP), 32'hFFFF_FFFE, 32'd3});
    vecs.push_back('{rtype(7'b0000001, 3'b110, OP), 32'd77, 32'd0});
    vecs.push_back('{rtype(7'b0000001, 3'b110, OP), 32'h8000_0000, 32'hFFFF_FFFF});
    foreach (vecs[i]) begin
      issue(vecs[i].inst, vecs[i].a, vecs[i].b, 1'b1, 5'(i + 1));
    end
    issue(NOP, 32'd0, 32'd0, 1'b0, 5'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
